mdio_peripheral: RTL and testbench

- Management-device (PHY-side) end of the MDIO Clause 22 link; the counterpart to the team's MDIO controller (STA).
- Decodes serial frames arriving on MDC and the controller's MDIO_OUT/MDIO_OE, and turns them into single-cycle register-file write and read strobes.
- On read frames, drives the 16-bit register value back on MDIO_IN.
- Sits between the MDIO pins and a local 32x16 register file, all in the CLK domain.

---
 rtl/mdio_pkg.sv | 49 ++++
 rtl/mdio_peripheral_mdc_edge_detect.sv | 19 +
 rtl/mdio_peripheral.sv | 275 +++++++++++++++++++++++++++
 tb/tb_mdio_peripheral.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Shared MDIO Clause 22 peripheral definitions: FSM states, frame codes,
// field widths and the frame bit positions used to decode them.
package mdio_pkg;

  localparam int WIDTH_DATA = 16;

  localparam int ST_W    = 2;
  localparam int OP_W    = 2;
  localparam int PHYAD_W = 5;
  localparam int REGAD_W = 5;
  localparam int TA_W    = 2;
  localparam int DATA_W  = WIDTH_DATA;
  localparam int CNT_W   = 6;

  localparam logic [1:0] ST_CODE  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] TA_WRITE = 2'b10;

  localparam logic [CNT_W-1:0] FRAME_LEN    = 6'd32;
  localparam logic [CNT_W-1:0] PREAMBLE_LEN = 6'd32;

  // Index of the last bit of each field, counting frame bits from 0.
  localparam logic [CNT_W-1:0] POS_OP_LAST  = 6'd3;
  localparam logic [CNT_W-1:0] POS_PHY_LAST = 6'd8;
  localparam logic [CNT_W-1:0] POS_REG_LAST = 6'd13;
  localparam logic [CNT_W-1:0] POS_TA_LAST  = 6'd15;
  localparam logic [CNT_W-1:0] POS_DAT_LAST = 6'd31;

  typedef enum logic [3:0] {
    IDLE,
    ST,
    OP,
    PHYAD,
    REGAD,
    TA,
    WDATA,
    RDATA,
    SKIP
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v,
    input logic [CNT_W-1:0] lim
  );
    return (v == lim) ? v : v + 6'd1;
  endfunction

endpackage

// File: rtl/mdio_peripheral_mdc_edge_detect.sv
// MDC rising-edge detector in the CLK domain.
// Ports: CLK, RESET (sync, active-high), i_mdc, o_rise (one-CLK pulse).
module mdc_edge_detect (
  input  logic CLK,
  input  logic RESET,
  input  logic i_mdc,
  output logic o_rise
);

  logic r_mdc_q;

  always_ff @(posedge CLK) begin
    if (RESET) r_mdc_q <= 1'b0;
    else       r_mdc_q <= i_mdc;
  end

  assign o_rise = ~r_mdc_q & i_mdc;

endmodule

// File: rtl/mdio_peripheral.sv
// MDIO Clause 22 management-device end: decodes frames into register-file
// write/read strobes and serialises read data back on MDIO_IN.
// Ports: CLK, RESET (sync, active-high), MDC, MDIO_OUT, MDIO_OE in;
//   MDIO_IN, MDIO_DRV out; REG_ADDR, REG_WDATA, REG_WE, REG_RE out;
//   REG_RDATA in (valid 1 CLK after REG_RE); FRAME_ERR one-CLK pulse.
// Option: define MDIO_PREAMBLE_EN to require 32 preamble ones before ST.
module mdio_peripheral
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR = 5'd1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  MDC,
  input  logic                  MDIO_OUT,
  input  logic                  MDIO_OE,
  output logic                  MDIO_IN,
  output logic                  MDIO_DRV,
  output logic [4:0]            REG_ADDR,
  output logic [WIDTH_DATA-1:0] REG_WDATA,
  output logic                  REG_WE,
  output logic                  REG_RE,
  input  logic [WIDTH_DATA-1:0] REG_RDATA,
  output logic                  FRAME_ERR
);

  logic w_rise;

  mdc_edge_detect u_edge (
    .CLK   (CLK),
    .RESET (RESET),
    .i_mdc (MDC),
    .o_rise(w_rise)
  );

  state_t                r_state, w_state_n;
  logic [CNT_W-1:0]      r_bits,  w_bits_n;
  logic [WIDTH_DATA-2:0] r_sh,    w_sh_n;
  logic [WIDTH_DATA-1:0] r_rsh,   w_rsh_n;
  logic                  r_rd,    w_rd_n;
  logic                  r_re_d;

  logic                  r_in,    w_in_n;
  logic                  r_drv,   w_drv_n;
  logic [4:0]            r_addr,  w_addr_n;
  logic [WIDTH_DATA-1:0] r_wdata, w_wdata_n;
  logic                  r_we,    w_we_n;
  logic                  r_re,    w_re_n;
  logic                  r_err,   w_err_n;

`ifdef MDIO_PREAMBLE_EN
  logic [CNT_W-1:0]      r_pre,   w_pre_n;
`endif

  logic [WIDTH_DATA-1:0] w_sh_in;
  logic [4:0]            w_fld5;
  logic [1:0]            w_fld2;
  logic [CNT_W-1:0]      w_bits_inc;

  assign w_sh_in    = {r_sh, MDIO_OUT};
  assign w_fld5     = w_sh_in[4:0];
  assign w_fld2     = w_sh_in[1:0];
  assign w_bits_inc = sat_inc(r_bits, FRAME_LEN);

  always_comb begin
    w_state_n = r_state;
    w_bits_n  = r_bits;
    w_sh_n    = r_sh;
    // Read data arrives one CLK after REG_RE was seen by the file.
    w_rsh_n   = r_re_d ? REG_RDATA : r_rsh;
    w_rd_n    = r_rd;
    w_in_n    = r_in;
    w_drv_n   = r_drv;
    w_addr_n  = r_addr;
    w_wdata_n = r_wdata;
    w_we_n    = 1'b0;
    w_re_n    = 1'b0;
    w_err_n   = 1'b0;
`ifdef MDIO_PREAMBLE_EN
    w_pre_n   = r_pre;
`endif

    if (w_rise) begin
      w_bits_n = w_bits_inc;
      w_sh_n   = w_sh_in[WIDTH_DATA-2:0];

      unique case (r_state)
        IDLE: begin
          w_bits_n = '0;
`ifdef MDIO_PREAMBLE_EN
          if (!MDIO_OE) begin
            w_pre_n = '0;
          end else if (MDIO_OUT) begin
            w_pre_n = sat_inc(r_pre, PREAMBLE_LEN);
          end else if (r_pre == PREAMBLE_LEN) begin
            w_pre_n   = '0;
            w_state_n = ST;
            w_bits_n  = 6'd1;
          end else begin
            w_pre_n = '0;
          end
`else
          if (MDIO_OE && !MDIO_OUT) begin
            w_state_n = ST;
            w_bits_n  = 6'd1;
          end
`endif
        end

        ST: begin
          if (!MDIO_OE) begin
            w_err_n   = 1'b1;
            w_state_n = IDLE;
            w_bits_n  = '0;
          end else if (MDIO_OUT) begin
            w_state_n = OP;
          end else begin
            // Repeated 0: keep treating it as the leading ST bit.
            w_bits_n = r_bits;
          end
        end

        OP: begin
          if (!MDIO_OE) begin
            w_err_n   = 1'b1;
            w_state_n = IDLE;
            w_bits_n  = '0;
          end else if (r_bits == POS_OP_LAST) begin
            if (w_fld2 == OP_READ) begin
              w_rd_n    = 1'b1;
              w_state_n = PHYAD;
            end else if (w_fld2 == OP_WRITE) begin
              w_rd_n    = 1'b0;
              w_state_n = PHYAD;
            end else begin
              w_err_n   = 1'b1;
              w_state_n = SKIP;
            end
          end
        end

        PHYAD: begin
          if (!MDIO_OE) begin
            w_err_n   = 1'b1;
            w_state_n = IDLE;
            w_bits_n  = '0;
          end else if (r_bits == POS_PHY_LAST) begin
            // Another device's frame is silently ridden out.
            w_state_n = (w_fld5 == PHY_ADDR) ? REGAD : SKIP;
          end
        end

        REGAD: begin
          if (!MDIO_OE) begin
            w_err_n   = 1'b1;
            w_state_n = IDLE;
            w_bits_n  = '0;
          end else if (r_bits == POS_REG_LAST) begin
            w_addr_n  = w_fld5;
            w_re_n    = r_rd;
            w_state_n = TA;
          end
        end

        TA: begin
          if (r_rd) begin
            // The controller releases the line here; OE is don't-care.
            if (r_bits == POS_TA_LAST) begin
              w_drv_n   = 1'b1;
              w_in_n    = 1'b0;
              w_state_n = RDATA;
            end
          end else if (!MDIO_OE) begin
            w_err_n   = 1'b1;
            w_state_n = IDLE;
            w_bits_n  = '0;
          end else if (r_bits == POS_TA_LAST) begin
            if (w_fld2 == TA_WRITE) begin
              w_state_n = WDATA;
            end else begin
              w_err_n   = 1'b1;
              w_state_n = SKIP;
            end
          end
        end

        WDATA: begin
          if (!MDIO_OE) begin
            w_err_n   = 1'b1;
            w_state_n = IDLE;
            w_bits_n  = '0;
          end else if (r_bits == POS_DAT_LAST) begin
            w_wdata_n = w_sh_in;
            w_we_n    = 1'b1;
            w_state_n = IDLE;
            w_bits_n  = '0;
          end
        end

        RDATA: begin
          // Edge after the last bit: bit 0 has had its full MDC period.
          if (r_bits == FRAME_LEN) begin
            w_drv_n   = 1'b0;
            w_in_n    = 1'b0;
            w_state_n = IDLE;
            w_bits_n  = '0;
          end else begin
            w_in_n  = r_rsh[WIDTH_DATA-1];
            w_rsh_n = {r_rsh[WIDTH_DATA-2:0], 1'b0};
          end
        end

        SKIP: begin
          if (r_bits == POS_DAT_LAST) begin
            w_state_n = IDLE;
            w_bits_n  = '0;
          end
        end

        default: begin
          w_state_n = IDLE;
          w_bits_n  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
      r_bits  <= '0;
      r_sh    <= '0;
      r_rsh   <= '0;
      r_rd    <= 1'b0;
      r_re_d  <= 1'b0;
      r_in    <= 1'b0;
      r_drv   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_re    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_bits  <= w_bits_n;
      r_sh    <= w_sh_n;
      r_rsh   <= w_rsh_n;
      r_rd    <= w_rd_n;
      r_re_d  <= r_re;
      r_in    <= w_in_n;
      r_drv   <= w_drv_n;
      r_addr  <= w_addr_n;
      r_wdata <= w_wdata_n;
      r_we    <= w_we_n;
      r_re    <= w_re_n;
      r_err   <= w_err_n;
    end
  end

`ifdef MDIO_PREAMBLE_EN
  always_ff @(posedge CLK) begin
    if (RESET) r_pre <= '0;
    else       r_pre <= w_pre_n;
  end
`endif

  assign MDIO_IN   = r_in;
  assign MDIO_DRV  = r_drv;
  assign REG_ADDR  = r_addr;
  assign REG_WDATA = r_wdata;
  assign REG_WE    = r_we;
  assign REG_RE    = r_re;
  assign FRAME_ERR = r_err;

endmodule

// File: tb/tb_mdio_peripheral.sv
// Directed bench for mdio_peripheral: write, read, foreign-address,
// malformed frames, abort and mid-read reset.
module tb_mdio_peripheral;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        MDC = 1'b0;
  logic        MDIO_OUT = 1'b0;
  logic        MDIO_OE = 1'b0;
  logic        MDIO_IN;
  logic        MDIO_DRV;
  logic [4:0]  REG_ADDR;
  logic [15:0] REG_WDATA;
  logic        REG_WE;
  logic        REG_RE;
  logic [15:0] REG_RDATA = 16'h0;
  logic        FRAME_ERR;

  mdio_peripheral #(.PHY_ADDR(5'd1)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .MDC      (MDC),
    .MDIO_OUT (MDIO_OUT),
    .MDIO_OE  (MDIO_OE),
    .MDIO_IN  (MDIO_IN),
    .MDIO_DRV (MDIO_DRV),
    .REG_ADDR (REG_ADDR),
    .REG_WDATA(REG_WDATA),
    .REG_WE   (REG_WE),
    .REG_RE   (REG_RE),
    .REG_RDATA(REG_RDATA),
    .FRAME_ERR(FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  // Register file model: read data one CLK after REG_RE.
  logic [15:0] mem [32];
  always @(posedge CLK) begin
    if (REG_RE) REG_RDATA <= mem[REG_ADDR];
  end

  int          we_cnt = 0;
  int          re_cnt = 0;
  int          err_cnt = 0;
  int          drv_cnt = 0;
  int          both_cnt = 0;
  logic [4:0]  wa = 5'd0;
  logic [15:0] wd = 16'd0;
  logic [4:0]  ra = 5'd0;

  always @(negedge CLK) begin
    if (REG_WE) begin
      we_cnt <= we_cnt + 1;
      wa     <= REG_ADDR;
      wd     <= REG_WDATA;
    end
    if (REG_RE) begin
      re_cnt <= re_cnt + 1;
      ra     <= REG_ADDR;
    end
    if (FRAME_ERR)       err_cnt  <= err_cnt + 1;
    if (MDIO_DRV)        drv_cnt  <= drv_cnt + 1;
    if (REG_WE && REG_RE) both_cnt <= both_cnt + 1;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic mbit(input logic oe, input logic d,
                      output logic drv, output logic din);
    @(negedge CLK);
    MDC = 1'b0;
    MDIO_OE = oe;
    MDIO_OUT = d;
    repeat (3) @(negedge CLK);
    MDC = 1'b1;
    repeat (3) @(negedge CLK);
    drv = MDIO_DRV;
    din = MDIO_IN;
  endtask

  task automatic send(input logic oe, input logic [63:0] v, input int n);
    logic dv, di;
    for (int i = n - 1; i >= 0; i--) mbit(oe, v[i], dv, di);
  endtask

  task automatic idle(input int n);
    send(1'b0, 64'd0, n);
  endtask

  task automatic pre(input int n);
    send(1'b1, {64{1'b1}}, n);
  endtask

  task automatic wr_raw(input logic [1:0] op, input logic [4:0] phy,
                        input logic [4:0] rg, input logic [1:0] ta,
                        input logic [15:0] d);
    send(1'b1, {32'd0, 2'b01, op, phy, rg, ta, d}, 32);
    idle(2);
  endtask

  task automatic wr_frame(input logic [1:0] op, input logic [4:0] phy,
                          input logic [4:0] rg, input logic [1:0] ta,
                          input logic [15:0] d);
`ifdef MDIO_PREAMBLE_EN
    pre(32);
`endif
    wr_raw(op, phy, rg, ta, d);
  endtask

  task automatic rd_hdr(input logic [4:0] rg);
`ifdef MDIO_PREAMBLE_EN
    pre(32);
`endif
    send(1'b1, {50'd0, 2'b01, 2'b10, 5'd1, rg}, 14);
  endtask

  int          b_we, b_re, b_err, b_drv;
  logic        drv, din, drv_all;
  logic [15:0] word;

  task automatic base();
    idle(1);
    b_we = we_cnt;
    b_re = re_cnt;
    b_err = err_cnt;
    b_drv = drv_cnt;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'h0;
    mem[7] = 16'hA5C3;
    mem[4] = 16'hFFFF;

    repeat (4) @(negedge CLK);
    chk("rst_in",    {31'd0, MDIO_IN},   32'd0);
    chk("rst_drv",   {31'd0, MDIO_DRV},  32'd0);
    chk("rst_addr",  {27'd0, REG_ADDR},  32'd0);
    chk("rst_wdata", {16'd0, REG_WDATA}, 32'd0);
    chk("rst_we",    {31'd0, REG_WE},    32'd0);
    chk("rst_re",    {31'd0, REG_RE},    32'd0);
    chk("rst_err",   {31'd0, FRAME_ERR}, 32'd0);
    RESET = 1'b0;
    idle(2);

    // Write to this device
    base();
    wr_frame(2'b01, 5'd1, 5'd3, 2'b10, 16'hBEEF);
    chk("wr_we_cnt", we_cnt - b_we, 1);
    chk("wr_addr",   {27'd0, wa}, 3);
    chk("wr_data",   {16'd0, wd}, 32'h0000BEEF);
    chk("wr_drv",    drv_cnt - b_drv, 0);
    chk("wr_err",    err_cnt - b_err, 0);
    chk("wr_re",     re_cnt - b_re, 0);

    // Read from this device
    base();
    rd_hdr(5'd7);
    mbit(1'b0, 1'b0, drv, din);
    chk("ta1_drv", {31'd0, drv}, 0);
    mbit(1'b0, 1'b0, drv, din);
    chk("ta2_drv", {31'd0, drv}, 1);
    chk("ta2_in",  {31'd0, din}, 0);
    word = 16'd0;
    drv_all = 1'b1;
    for (int i = 0; i < 16; i++) begin
      mbit(1'b0, 1'b0, drv, din);
      word = {word[14:0], din};
      drv_all = drv_all & drv;
    end
    chk("rd_word", {16'd0, word}, 32'h0000A5C3);
    chk("rd_drv_held", {31'd0, drv_all}, 1);
    mbit(1'b0, 1'b0, drv, din);
    chk("rd_end_drv", {31'd0, drv}, 0);
    chk("rd_end_in",  {31'd0, din}, 0);
    idle(2);
    chk("rd_re_cnt", re_cnt - b_re, 1);
    chk("rd_addr",   {27'd0, ra}, 7);
    chk("rd_we",     we_cnt - b_we, 0);
    chk("rd_err",    err_cnt - b_err, 0);

    // Frame for another PHY, then a valid one
    base();
    wr_frame(2'b01, 5'd2, 5'd3, 2'b10, 16'h1111);
    chk("oth_we",  we_cnt - b_we, 0);
    chk("oth_re",  re_cnt - b_re, 0);
    chk("oth_err", err_cnt - b_err, 0);
    chk("oth_drv", drv_cnt - b_drv, 0);
    wr_frame(2'b01, 5'd1, 5'd5, 2'b10, 16'h1234);
    chk("oth_next_we",   we_cnt - b_we, 1);
    chk("oth_next_data", {16'd0, wd}, 32'h00001234);

    // OP=11
    base();
    wr_frame(2'b11, 5'd1, 5'd4, 2'b10, 16'h5555);
    chk("op11_err", err_cnt - b_err, 1);
    chk("op11_we",  we_cnt - b_we, 0);
    chk("op11_re",  re_cnt - b_re, 0);

    // Write with bad turnaround
    base();
    wr_frame(2'b01, 5'd1, 5'd6, 2'b00, 16'h7777);
    chk("ta00_err", err_cnt - b_err, 1);
    chk("ta00_we",  we_cnt - b_we, 0);

    // OE dropped during PHYAD, then a valid frame
    base();
`ifdef MDIO_PREAMBLE_EN
    pre(32);
`endif
    send(1'b1, {58'd0, 2'b01, 2'b01, 2'b00}, 6);
    mbit(1'b0, 1'b0, drv, din);
    idle(3);
    chk("abort_err", err_cnt - b_err, 1);
    chk("abort_we",  we_cnt - b_we, 0);
    wr_frame(2'b01, 5'd1, 5'd10, 2'b10, 16'hC0DE);
    chk("abort_next_we",   we_cnt - b_we, 1);
    chk("abort_next_addr", {27'd0, wa}, 10);

    // Reset at the 5th read data bit
    base();
    rd_hdr(5'd7);
    send(1'b0, 64'd0, 2 + 4);
    mbit(1'b0, 1'b0, drv, din);
    chk("rrst_pre_drv", {31'd0, drv}, 1);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    chk("rrst_drv", {31'd0, MDIO_DRV}, 0);
    chk("rrst_in",  {31'd0, MDIO_IN}, 0);
    RESET = 1'b0;
    idle(3);
    chk("rrst_we", we_cnt - b_we, 0);
    wr_frame(2'b01, 5'd1, 5'd9, 2'b10, 16'h5A5A);
    chk("rrst_next_we",   we_cnt - b_we, 1);
    chk("rrst_next_data", {16'd0, wd}, 32'h00005A5A);
    chk("rrst_next_addr", {27'd0, wa}, 9);

`ifdef MDIO_PREAMBLE_EN
    base();
    pre(31);
    wr_raw(2'b01, 5'd1, 5'd2, 2'b10, 16'h0F0F);
    chk("pre31_we", we_cnt - b_we, 0);
    pre(32);
    wr_raw(2'b01, 5'd1, 5'd2, 2'b10, 16'h0F0F);
    chk("pre32_we",   we_cnt - b_we, 1);
    chk("pre32_data", {16'd0, wd}, 32'h00000F0F);
`endif

    chk("no_dual_strobe", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
